servo_cmd_arbiter: RTL and testbench

//  Shares a bank of NUM_CH servo controller channels between two command requesters: host (SPI register path) and auto (on-chip motion script).

---
 rtl/servo_pkg.sv | 23 ++
 rtl/servo_ch_timer.sv | 46 ++++
 rtl/servo_cmd_arbiter.sv | 142 ++++++++++++++
 tb/tb_servo_cmd_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo command arbiter.
package servo_pkg;

    localparam int RATIO_W  = 8;
    localparam int SETTLE_W = 16;
    localparam int WDOG_W   = 24;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam logic GRANT_HOST = 1'b0;
    localparam logic GRANT_AUTO = 1'b1;

    // Command payload after arbitration; the channel index travels separately
    // because its width is a parameter of the top.
    typedef struct packed {
        logic               en;
        logic [RATIO_W-1:0] ratio;
    } cmd_t;

endpackage

// File: rtl/servo_ch_timer.sv
// Per-channel settle counter plus optional idle watchdog (SERVO_WDOG_EN).
module servo_ch_timer
    import servo_pkg::*;
#(
    parameter logic [SETTLE_W-1:0] SETTLE_CYCLES = 16'd4000,
    parameter logic [WDOG_W-1:0]   WDOG_CYCLES   = 24'd5000000
)(
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic busy,
    output logic wdog_hit
);

    logic [SETTLE_W-1:0] settle_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n)
            settle_cnt <= '0;
        else if (load)
            settle_cnt <= SETTLE_CYCLES;
        else if (settle_cnt != '0)
            settle_cnt <= settle_cnt - 1'b1;
    end

    assign busy = (settle_cnt != '0);

`ifdef SERVO_WDOG_EN
    logic [WDOG_W-1:0] idle_cnt;

    // Fires on the clock that completes WDOG_CYCLES enabled, command-free cycles.
    assign wdog_hit = enable && (idle_cnt == WDOG_CYCLES - 1'b1);

    always_ff @(posedge clock) begin
        if (!reset_n || load || !enable || wdog_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    wire [WDOG_W:0] unused_wdog = {enable, WDOG_CYCLES};
    assign wdog_hit = 1'b0;
`endif

endmodule

// File: rtl/servo_cmd_arbiter.sv
// Round-robin host/auto command arbiter and per-channel servo register bank.
// Optional idle watchdog per channel when SERVO_WDOG_EN is defined.
module servo_cmd_arbiter
    import servo_pkg::*;
#(
    parameter int                  NUM_CH        = 4,
    parameter int                  CH_W          = 3,
    parameter logic [SETTLE_W-1:0] SETTLE_CYCLES = 16'd4000,
    parameter logic [RATIO_W-1:0]  HOME_RATIO    = 8'h80,
    parameter logic [WDOG_W-1:0]   WDOG_CYCLES   = 24'd5000000
)(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      host_valid,
    output logic                      host_ready,
    input  logic [CH_W-1:0]           host_ch,
    input  logic                      host_en,
    input  logic [RATIO_W-1:0]        host_ratio,
    input  logic                      auto_valid,
    output logic                      auto_ready,
    input  logic [CH_W-1:0]           auto_ch,
    input  logic                      auto_en,
    input  logic [RATIO_W-1:0]        auto_ratio,
    output logic [NUM_CH-1:0]         servo_enable,
    output logic [NUM_CH*RATIO_W-1:0] servo_start,
    output logic [NUM_CH*RATIO_W-1:0] servo_target,
    output logic [NUM_CH-1:0]         ch_busy,
    output logic                      err_stb,
    output logic [NUM_CH-1:0]         wdog_trip
);

    localparam int              CH_SPAN  = 2**CH_W;
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic [NUM_CH-1:0][RATIO_W-1:0] start_q, target_q;
    logic [NUM_CH-1:0]              enable_q, trip_q, load, busy, wdog_hit;
    logic [CH_SPAN-1:0]             busy_ext;

    arb_state_t      arb_state;
    logic            last_grant;
    logic            bad_ch_q;
    logic            host_in, auto_in, host_elig, auto_elig;
    logic            grant_host, grant_auto, accept, sel_in;
    logic [CH_W-1:0] sel_ch;
    cmd_t            sel_cmd;

    // Out-of-range channel indices read as never busy.
    always_comb begin
        busy_ext = '0;
        busy_ext[NUM_CH-1:0] = busy;
    end

    assign host_in   = ({1'b0, host_ch} < NUM_CH_L);
    assign auto_in   = ({1'b0, auto_ch} < NUM_CH_L);
    assign host_elig = host_valid && !busy_ext[host_ch];
    assign auto_elig = auto_valid && !busy_ext[auto_ch];

    // A tie goes to whoever did not win last; at most one grant per cycle.
    assign grant_host = host_elig && (!auto_elig || last_grant == GRANT_AUTO);
    assign grant_auto = auto_elig && !grant_host;
    assign accept     = grant_host || grant_auto;
    assign host_ready = grant_host;
    assign auto_ready = grant_auto;

    assign sel_ch  = grant_host ? host_ch : auto_ch;
    assign sel_in  = grant_host ? host_in : auto_in;
    assign sel_cmd = grant_host ? cmd_t'{host_en, host_ratio} : cmd_t'{auto_en, auto_ratio};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            arb_state  <= ARB_IDLE;
            last_grant <= GRANT_AUTO;
            bad_ch_q   <= 1'b0;
        end else begin
            bad_ch_q <= accept && !sel_in;
            if (accept) begin
                arb_state  <= ARB_GRANT;
                last_grant <= grant_host ? GRANT_HOST : GRANT_AUTO;
            end else begin
                arb_state  <= ARB_IDLE;
            end
        end
    end

    assign err_stb = (arb_state == ARB_GRANT) && bad_ch_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic               en_r, trip_r;
        logic [RATIO_W-1:0] start_r, target_r;

        assign load[i] = accept && sel_in && (sel_ch == CH_W'(i));

        servo_ch_timer #(
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .WDOG_CYCLES   (WDOG_CYCLES)
        ) u_timer (
            .clock    (clock),
            .reset_n  (reset_n),
            .load     (load[i]),
            .enable   (en_r),
            .busy     (busy[i]),
            .wdog_hit (wdog_hit[i])
        );

        // A command always beats a same-cycle watchdog trip.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                en_r     <= 1'b0;
                trip_r   <= 1'b0;
                start_r  <= HOME_RATIO;
                target_r <= HOME_RATIO;
            end else if (load[i]) begin
                if (sel_cmd.en) begin
                    target_r <= sel_cmd.ratio;
                    if (!en_r)
                        start_r <= sel_cmd.ratio;
                    en_r   <= 1'b1;
                    trip_r <= 1'b0;
                end else begin
                    en_r    <= 1'b0;
                    start_r <= target_r;
                end
            end else if (wdog_hit[i]) begin
                en_r    <= 1'b0;
                start_r <= target_r;
                trip_r  <= 1'b1;
            end
        end

        assign enable_q[i] = en_r;
        assign trip_q[i]   = trip_r;
        assign start_q[i]  = start_r;
        assign target_q[i] = target_r;
    end

    assign servo_enable = enable_q;
    assign servo_start  = start_q;
    assign servo_target = target_q;
    assign ch_busy      = busy;
    assign wdog_trip    = trip_q;

endmodule

// File: tb/tb_servo_cmd_arbiter.sv
// Directed bench for servo_cmd_arbiter; covers the watchdog when SERVO_WDOG_EN is defined.
module tb_servo_cmd_arbiter;

`ifdef SERVO_WDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        host_valid, host_ready, host_en;
    logic [2:0]  host_ch;
    logic [7:0]  host_ratio;
    logic        auto_valid, auto_ready, auto_en;
    logic [2:0]  auto_ch;
    logic [7:0]  auto_ratio;
    logic [3:0]  servo_enable, ch_busy, wdog_trip;
    logic [31:0] servo_start, servo_target;
    logic        err_stb;

    int n_tests = 0;
    int n_fail  = 0;
    int waited;

    servo_cmd_arbiter #(
        .NUM_CH        (4),
        .CH_W          (3),
        .SETTLE_CYCLES (16'd4000),
        .HOME_RATIO    (8'h80),
        .WDOG_CYCLES   (24'd100)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_ch      (host_ch),
        .host_en      (host_en),
        .host_ratio   (host_ratio),
        .auto_valid   (auto_valid),
        .auto_ready   (auto_ready),
        .auto_ch      (auto_ch),
        .auto_en      (auto_en),
        .auto_ratio   (auto_ratio),
        .servo_enable (servo_enable),
        .servo_start  (servo_start),
        .servo_target (servo_target),
        .ch_busy      (ch_busy),
        .err_stb      (err_stb),
        .wdog_trip    (wdog_trip)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_cmd(input logic [2:0] ch, input logic en, input logic [7:0] r);
        host_valid = 1'b1; host_ch = ch; host_en = en; host_ratio = r;
    endtask

    task automatic auto_cmd(input logic [2:0] ch, input logic en, input logic [7:0] r);
        auto_valid = 1'b1; auto_ch = ch; auto_en = en; auto_ratio = r;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        host_valid = 1'b0; host_ch = '0; host_en = 1'b0; host_ratio = '0;
        auto_valid = 1'b0; auto_ch = '0; auto_en = 1'b0; auto_ratio = '0;

        // Reset
        repeat (2) tick();
        check("rst_enable", servo_enable, 4'h0);
        check("rst_start",  servo_start,  32'h80808080);
        check("rst_target", servo_target, 32'h80808080);
        check("rst_busy",   ch_busy,      4'h0);
        check("rst_err",    err_stb,      1'b0);
        check("rst_trip",   wdog_trip,    4'h0);
        check("rst_ready",  {host_ready, auto_ready}, 2'b00);
        reset_n = 1'b1;

        // Host enables ch1 at C0
        host_cmd(3'd1, 1'b1, 8'hC0);
        #1;
        check("t2_ready", {host_ready, auto_ready}, 2'b10);
        tick();
        host_valid = 1'b0;
        check("t2_enable", servo_enable, 4'b0010);
        check("t2_start",  servo_start,  32'h8080C080);
        check("t2_target", servo_target, 32'h8080C080);
        check("t2_busy",   ch_busy,      4'b0010);

        // Auto waits on busy ch1, accepted the cycle busy falls
        auto_cmd(3'd1, 1'b1, 8'h40);
        #1;
        check("t4_blocked", auto_ready, 1'b0);
        repeat (3999) tick();
        check("t4_busy_last", ch_busy[1], 1'b1);
        check("t4_still_blocked", auto_ready, 1'b0);
        tick();
        check("t4_busy_fall", ch_busy[1], 1'b0);
        check("t4_ready", auto_ready, 1'b1);
        tick();
        auto_valid = 1'b0;
        check("t4_target1", servo_target[15:8], 8'h40);
        check("t4_start1",  servo_start[15:8],  WD ? 8'h40 : 8'hC0);
        check("t4_enable1", servo_enable[1], 1'b1);
        check("t4_rebusy",  ch_busy[1], 1'b1);

        // Dual requests on different channels: host (last was auto), then auto
        host_cmd(3'd0, 1'b1, 8'h11);
        auto_cmd(3'd2, 1'b1, 8'h22);
        #1;
        check("t3_grant_host", {host_ready, auto_ready}, 2'b10);
        tick();
        check("t3_grant_auto", {host_ready, auto_ready}, 2'b01);
        tick();
        check("t3_none", {host_ready, auto_ready}, 2'b00);
        host_valid = 1'b0; auto_valid = 1'b0;
        check("t3_enable", servo_enable, 4'b0111);
        check("t3_target", servo_target, 32'h80224011);
        check("t3_start",  servo_start,  {8'h80, 8'h22, (WD ? 8'h40 : 8'hC0), 8'h11});

        // Same-channel tie: host wins, auto waits out the settle window
        host_cmd(3'd3, 1'b1, 8'h33);
        auto_cmd(3'd3, 1'b1, 8'h44);
        #1;
        check("tie_grant", {host_ready, auto_ready}, 2'b10);
        tick();
        host_valid = 1'b0;
        #1;
        check("tie_auto_blocked", auto_ready, 1'b0);
        check("tie_busy3", ch_busy[3], 1'b1);
        waited = 0;
        while (!auto_ready && waited <= 4100) begin
            tick();
            waited++;
        end
        check("tie_wait_cycles", waited, 4000);
        tick();
        auto_valid = 1'b0;
        check("tie_target3", servo_target[31:24], 8'h44);
        check("tie_start3",  servo_start[31:24],  WD ? 8'h44 : 8'h33);
        check("tie_enable3", servo_enable[3], 1'b1);

        // Out-of-range channels
        host_cmd(3'd6, 1'b1, 8'h55);
        #1;
        check("err6_ready", host_ready, 1'b1);
        check("err6_pre", err_stb, 1'b0);
        tick();
        host_valid = 1'b0;
        check("err6_stb", err_stb, 1'b1);
        check("err6_target", servo_target, 32'h44224011);
        tick();
        check("err6_pulse_end", err_stb, 1'b0);

        host_cmd(3'd7, 1'b1, 8'h57);
        auto_cmd(3'd5, 1'b1, 8'h5A);
        #1;
        check("err_rr_grant", {host_ready, auto_ready}, 2'b01);
        tick();
        host_valid = 1'b0; auto_valid = 1'b0;
        check("err5_stb", err_stb, 1'b1);

        host_cmd(3'd4, 1'b1, 8'h66);
        #1;
        check("err4_ready", host_ready, 1'b1);
        tick();
        host_valid = 1'b0;
        check("err4_stb", err_stb, 1'b1);
        check("err4_target", servo_target, 32'h44224011);

        // Disable ch2: parks start at target
        host_cmd(3'd2, 1'b0, 8'h99);
        #1;
        check("dis_ready", host_ready, 1'b1);
        tick();
        host_valid = 1'b0;
        check("dis_enable2", servo_enable[2], 1'b0);
        check("dis_start2",  servo_start[23:16],  8'h22);
        check("dis_target2", servo_target[23:16], 8'h22);

        // Reset mid-settle with a pending command
        host_cmd(3'd0, 1'b1, 8'hAA);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        host_valid = 1'b0;
        check("mrst_target", servo_target, 32'h80808080);
        check("mrst_start",  servo_start,  32'h80808080);
        check("mrst_enable", servo_enable, 4'h0);
        check("mrst_busy",   ch_busy,      4'h0);
        host_cmd(3'd0, 1'b1, 8'h01);
        auto_cmd(3'd1, 1'b1, 8'h02);
        #1;
        check("mrst_host_first", {host_ready, auto_ready}, 2'b10);
        host_valid = 1'b0; auto_valid = 1'b0;

`ifdef SERVO_WDOG_EN
        // Watchdog trips after 100 idle enabled clocks; en=1 command clears it
        host_cmd(3'd3, 1'b1, 8'h77);
        #1;
        tick();
        host_valid = 1'b0;
        check("wd_enable_on", servo_enable[3], 1'b1);
        repeat (99) tick();
        check("wd_not_yet", {servo_enable[3], wdog_trip[3]}, 2'b10);
        tick();
        check("wd_enable_off", servo_enable[3], 1'b0);
        check("wd_trip", wdog_trip, 4'b1000);
        check("wd_start_park", servo_start[31:24], 8'h77);
        host_cmd(3'd3, 1'b1, 8'h78);
        #1;
        waited = 0;
        while (!host_ready && waited <= 5000) begin
            tick();
            waited++;
        end
        check("wd_rearm_timeout", waited <= 5000, 1'b1);
        tick();
        host_valid = 1'b0;
        check("wd_trip_clear", wdog_trip, 4'h0);
        check("wd_reenable", servo_enable[3], 1'b1);
`else
        // Without the watchdog an idle enabled channel stays enabled
        host_cmd(3'd3, 1'b1, 8'h77);
        #1;
        tick();
        host_valid = 1'b0;
        repeat (200) tick();
        check("nowd_enable", servo_enable[3], 1'b1);
        check("nowd_trip", wdog_trip, 4'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
